// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register that sits in front of the ALU.
// It forwards from the EX/MEM and MEM/WB buses, picks the register or the
// immediate for operand 2, and decodes ALUOp/funct into the 4-bit ALU code.
// Optional feature macro: ALU_OPERAND_FWD_EN. When it is defined, forwarding
// and hold refresh are enabled. When it is undefined, the operands are the
// raw register-file data, but the forwarding ports stay on the interface.
module alu_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_rs_addr,
  input  logic [4:0]       in_rt_addr,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [4:0]       in_rd_addr,
  input  logic             flush,
  input  logic             ex_stall,
  input  logic             exmem_we,
  input  logic [4:0]       exmem_addr,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_we,
  input  logic [4:0]       memwb_addr,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] Read_data_1,
  output logic [WIDTH-1:0] Read_data_2,
  output logic [3:0]       ALUControl,
  output logic [4:0]       out_rd_addr,
  output logic             out_illegal
);

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] readData1_q, readData1_d;
  logic [WIDTH-1:0] readData2_q, readData2_d;
  logic [3:0]       aluControl_q, aluControl_d;
  logic [4:0]       rdAddr_q, rdAddr_d;
  logic             illegal_q, illegal_d;

  logic             load;
  logic [WIDTH-1:0] rsValue;
  logic [WIDTH-1:0] rtValue;
  logic [3:0]       decCtl;
  logic             decIllegal;

`ifdef ALU_OPERAND_FWD_EN
  // Source addresses and alusrc are kept so that a stalled instruction can
  // keep picking up results that are written back while it waits.
  logic [4:0] rsAddr_q, rsAddr_d;
  logic [4:0] rtAddr_q, rtAddr_d;
  logic       aluSrc_q, aluSrc_d;

  // EX/MEM is the younger result, so it wins over MEM/WB. Register 0 is
  // hard-wired, so it never forwards.
  function automatic logic [WIDTH-1:0] forwardValue(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] raw,
    input logic             exWe,
    input logic [4:0]       exAddr,
    input logic [WIDTH-1:0] exData,
    input logic             wbWe,
    input logic [4:0]       wbAddr,
    input logic [WIDTH-1:0] wbData
  );
    logic [WIDTH-1:0] result;
    result = raw;
    if (addr != 5'd0) begin
      if (exWe && (exAddr == addr)) begin
        result = exData;
      end else if (wbWe && (wbAddr == addr)) begin
        result = wbData;
      end
    end
    return result;
  endfunction

  assign rsValue = forwardValue(in_rs_addr, in_rs_data, exmem_we, exmem_addr,
                                exmem_data, memwb_we, memwb_addr, memwb_data);
  assign rtValue = forwardValue(in_rt_addr, in_rt_data, exmem_we, exmem_addr,
                                exmem_data, memwb_we, memwb_addr, memwb_data);
`else
  // Without forwarding, the bypass buses and source addresses go unused.
  logic unusedFwd;
  assign unusedFwd = ^{exmem_we, exmem_addr, exmem_data,
                       memwb_we, memwb_addr, memwb_data,
                       in_rs_addr, in_rt_addr};

  assign rsValue = in_rs_data;
  assign rtValue = in_rt_data;
`endif

  // A full stage only frees up when the consumer is not stalled.
  assign in_ready = !outValid_q || !ex_stall;
  assign load     = in_valid && in_ready;

  // Main-decoder ALUOp plus funct produce the ALU code. Unsupported
  // combinations fall back to add and raise the illegal flag.
  always_comb begin
    decCtl     = 4'b0010;
    decIllegal = 1'b0;
    case (in_aluop)
      2'b00: decCtl = 4'b0010;
      2'b01: decCtl = 4'b0110;
      2'b10: begin
        case (in_funct)
          6'b100000: decCtl = 4'b0010;
          6'b100010: decCtl = 4'b0110;
          6'b100100: decCtl = 4'b0000;
          6'b100101: decCtl = 4'b0001;
          6'b101010: decCtl = 4'b0111;
          default:   decIllegal = 1'b1;
        endcase
      end
      default: decIllegal = 1'b1;
    endcase
  end

  // Next state. Flush beats load, load beats bubble, and a blocked stage
  // holds its contents (refreshing operands when forwarding is enabled).
  always_comb begin
    outValid_d   = outValid_q;
    readData1_d  = readData1_q;
    readData2_d  = readData2_q;
    aluControl_d = aluControl_q;
    rdAddr_d     = rdAddr_q;
    illegal_d    = illegal_q;
`ifdef ALU_OPERAND_FWD_EN
    rsAddr_d     = rsAddr_q;
    rtAddr_d     = rtAddr_q;
    aluSrc_d     = aluSrc_q;
`endif
    if (flush) begin
      outValid_d = 1'b0;
    end else if (load) begin
      outValid_d   = 1'b1;
      readData1_d  = rsValue;
      readData2_d  = in_alusrc ? in_imm : rtValue;
      aluControl_d = decCtl;
      illegal_d    = decIllegal;
      rdAddr_d     = in_rd_addr;
`ifdef ALU_OPERAND_FWD_EN
      rsAddr_d     = in_rs_addr;
      rtAddr_d     = in_rt_addr;
      aluSrc_d     = in_alusrc;
`endif
    end else if (in_ready) begin
      outValid_d = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    end else begin
      // Not ready here means the stage is full and stalled.
      readData1_d = forwardValue(rsAddr_q, readData1_q, exmem_we, exmem_addr,
                                 exmem_data, memwb_we, memwb_addr, memwb_data);
      if (!aluSrc_q) begin
        readData2_d = forwardValue(rtAddr_q, readData2_q, exmem_we, exmem_addr,
                                   exmem_data, memwb_we, memwb_addr, memwb_data);
      end
`endif
    end
  end

  // Pipeline register. Asynchronous reset drops any held instruction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q   <= 1'b0;
      readData1_q  <= '0;
      readData2_q  <= '0;
      aluControl_q <= 4'b0000;
      rdAddr_q     <= 5'd0;
      illegal_q    <= 1'b0;
`ifdef ALU_OPERAND_FWD_EN
      rsAddr_q     <= 5'd0;
      rtAddr_q     <= 5'd0;
      aluSrc_q     <= 1'b0;
`endif
    end else begin
      outValid_q   <= outValid_d;
      readData1_q  <= readData1_d;
      readData2_q  <= readData2_d;
      aluControl_q <= aluControl_d;
      rdAddr_q     <= rdAddr_d;
      illegal_q    <= illegal_d;
`ifdef ALU_OPERAND_FWD_EN
      rsAddr_q     <= rsAddr_d;
      rtAddr_q     <= rtAddr_d;
      aluSrc_q     <= aluSrc_d;
`endif
    end
  end

  assign out_valid   = outValid_q;
  assign Read_data_1 = readData1_q;
  assign Read_data_2 = readData2_q;
  assign ALUControl  = aluControl_q;
  assign out_rd_addr = rdAddr_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: self-checking bench for alu_operand_stage.
// It uses directed cases plus a randomized run. Both are compared with a
// transaction-level reference model that tracks the ALU_OPERAND_FWD_EN macro.
module tb_alu_operand_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [5:0]       in_funct;
  logic [4:0]       in_rs_addr;
  logic [4:0]       in_rt_addr;
  logic [WIDTH-1:0] in_rs_data;
  logic [WIDTH-1:0] in_rt_data;
  logic [WIDTH-1:0] in_imm;
  logic             in_alusrc;
  logic [4:0]       in_rd_addr;
  logic             flush;
  logic             ex_stall;
  logic             exmem_we;
  logic [4:0]       exmem_addr;
  logic [WIDTH-1:0] exmem_data;
  logic             memwb_we;
  logic [4:0]       memwb_addr;
  logic [WIDTH-1:0] memwb_data;
  logic             out_valid;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic [3:0]       ALUControl;
  logic [4:0]       out_rd_addr;
  logic             out_illegal;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference state. This is the instruction the stage should be presenting.
  logic             expValid;
  logic [WIDTH-1:0] expOp1;
  logic [WIDTH-1:0] expOp2;
  logic [3:0]       expCtl;
  logic             expIllegal;
  logic [4:0]       expRd;
  logic [4:0]       expRsAddr;
  logic [4:0]       expRtAddr;
  logic             expUsesImm;

  alu_operand_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_rd_addr(in_rd_addr),
    .flush(flush), .ex_stall(ex_stall),
    .exmem_we(exmem_we), .exmem_addr(exmem_addr), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_addr(memwb_addr), .memwb_data(memwb_data),
    .out_valid(out_valid), .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
    .ALUControl(ALUControl), .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns the value that a read of register addr sees this cycle.
  function automatic logic [WIDTH-1:0] refRead(input logic [4:0] addr,
                                               input logic [WIDTH-1:0] raw);
`ifdef ALU_OPERAND_FWD_EN
    if (addr == 0) return raw;
    if (exmem_we && exmem_addr == addr) return exmem_data;
    if (memwb_we && memwb_addr == addr) return memwb_data;
`endif
    return raw;
  endfunction

  // ALU code table: {illegal, code}.
  function automatic logic [4:0] refDecode(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (op == 2'd2) begin
      if (fn == 6'd32) return {1'b0, 4'd2};
      if (fn == 6'd34) return {1'b0, 4'd6};
      if (fn == 6'd36) return {1'b0, 4'd0};
      if (fn == 6'd37) return {1'b0, 4'd1};
      if (fn == 6'd42) return {1'b0, 4'd7};
    end
    return {1'b1, 4'd2};
  endfunction

  task automatic modelEdge();
    logic [4:0] dec;
    logic       canTake;
    canTake = !expValid || !ex_stall;
    if (flush) begin
      expValid = 1'b0;
    end else if (in_valid && canTake) begin
      dec        = refDecode(in_aluop, in_funct);
      expValid   = 1'b1;
      expOp1     = refRead(in_rs_addr, in_rs_data);
      expOp2     = in_alusrc ? in_imm : refRead(in_rt_addr, in_rt_data);
      expCtl     = dec[3:0];
      expIllegal = dec[4];
      expRd      = in_rd_addr;
      expRsAddr  = in_rs_addr;
      expRtAddr  = in_rt_addr;
      expUsesImm = in_alusrc;
    end else if (canTake) begin
      expValid = 1'b0;
    end else begin
      expOp1 = refRead(expRsAddr, expOp1);
      if (!expUsesImm) expOp2 = refRead(expRtAddr, expOp2);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, WIDTH'(out_valid), WIDTH'(expValid));
    if (expValid) begin
      checkOutput({tag, ".op1"}, Read_data_1, expOp1);
      checkOutput({tag, ".op2"}, Read_data_2, expOp2);
      checkOutput({tag, ".ctl"}, WIDTH'(ALUControl), WIDTH'(expCtl));
      checkOutput({tag, ".illegal"}, WIDTH'(out_illegal), WIDTH'(expIllegal));
      checkOutput({tag, ".rd"}, WIDTH'(out_rd_addr), WIDTH'(expRd));
    end
  endtask

  // This task is called at a falling edge, after the inputs are driven.
  // It checks in_ready, moves the model and the DUT through one rising edge,
  // and then checks the outputs.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput({tag, ".ready"}, WIDTH'(in_ready), WIDTH'(!expValid || !ex_stall));
    modelEdge();
    @(posedge clk);
    #1;
    compareAll(tag);
    @(negedge clk);
  endtask

  task automatic setIdle();
    in_valid = 0; in_aluop = 2'b10; in_funct = 6'b100000;
    in_rs_addr = 0; in_rt_addr = 0; in_rs_data = 0; in_rt_data = 0;
    in_imm = 0; in_alusrc = 0; in_rd_addr = 0; flush = 0; ex_stall = 0;
    exmem_we = 0; exmem_addr = 0; exmem_data = 0;
    memwb_we = 0; memwb_addr = 0; memwb_data = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    expValid = 0; expOp1 = 0; expOp2 = 0; expCtl = 0; expIllegal = 0;
    expRd = 0; expRsAddr = 0; expRtAddr = 0; expUsesImm = 0;
    checkOutput("reset.valid", WIDTH'(out_valid), 0);
    checkOutput("reset.op1", Read_data_1, 0);
    checkOutput("reset.op2", Read_data_2, 0);
    checkOutput("reset.ctl", WIDTH'(ALUControl), 0);
    checkOutput("reset.rd", WIDTH'(out_rd_addr), 0);
    checkOutput("reset.illegal", WIDTH'(out_illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic loadOne(input string tag, input logic [1:0] op, input logic [5:0] fn);
    setIdle();
    in_valid = 1; in_aluop = op; in_funct = fn;
    in_rs_addr = 5'd1; in_rt_addr = 5'd2;
    in_rs_data = 32'd5; in_rt_data = 32'd7; in_rd_addr = 5'd9;
    applyStimulus(tag);
  endtask

  initial begin
    setIdle();
    rst_n = 1'b0;
    @(negedge clk);
    doReset();

    // The first instruction after reset is a plain add.
    loadOne("add", 2'b10, 6'b100000);
    checkOutput("add.op1.const", Read_data_1, 32'd5);
    checkOutput("add.op2.const", Read_data_2, 32'd7);
    checkOutput("add.ctl.const", WIDTH'(ALUControl), 32'd2);

    // EX/MEM wins over MEM/WB for the same register.
    setIdle();
    in_valid = 1; in_rs_addr = 5'd3; in_rs_data = 32'h11;
    exmem_we = 1; exmem_addr = 5'd3; exmem_data = 32'hAA;
    memwb_we = 1; memwb_addr = 5'd3; memwb_data = 32'hBB;
    applyStimulus("fwdprio");
`ifdef ALU_OPERAND_FWD_EN
    checkOutput("fwdprio.const", Read_data_1, 32'hAA);
`else
    checkOutput("fwdprio.const", Read_data_1, 32'h11);
`endif

    // A write to register 0 never forwards.
    setIdle();
    in_valid = 1; in_rs_addr = 5'd0; in_rs_data = 32'h42;
    exmem_we = 1; exmem_addr = 5'd0; exmem_data = 32'hFF;
    applyStimulus("addr0");
    checkOutput("addr0.const", Read_data_1, 32'h42);

    // A write that lands during a stall must reach the held operand.
    setIdle();
    in_valid = 1; in_rt_addr = 5'd4; in_rt_data = 32'h9; in_alusrc = 0;
    applyStimulus("stall.load");
    setIdle();
    ex_stall = 1; memwb_we = 1; memwb_addr = 5'd4; memwb_data = 32'h1234;
    in_valid = 1;
    applyStimulus("stall.c1");
    setIdle();
    ex_stall = 1; in_valid = 1;
    applyStimulus("stall.c2");
`ifdef ALU_OPERAND_FWD_EN
    checkOutput("stall.op2.const", Read_data_2, 32'h1234);
`else
    checkOutput("stall.op2.const", Read_data_2, 32'h9);
`endif
    checkOutput("stall.valid.const", WIDTH'(out_valid), 32'd1);

    // When flush and a valid input arrive together, the input is consumed
    // and then killed.
    setIdle();
    in_valid = 1; flush = 1;
    #1;
    checkOutput("flush.ready.const", WIDTH'(in_ready), 32'd1);
    applyStimulus("flush");

    // Decode sweep, including the illegal combinations.
    loadOne("dec00", 2'b00, 6'b111111);
    loadOne("dec01", 2'b01, 6'b000000);
    loadOne("decsub", 2'b10, 6'b100010);
    loadOne("decand", 2'b10, 6'b100100);
    loadOne("decor", 2'b10, 6'b100101);
    loadOne("decslt", 2'b10, 6'b101010);
    checkOutput("decslt.ctl.const", WIDTH'(ALUControl), 32'd7);
    loadOne("decbad", 2'b10, 6'b000000);
    checkOutput("decbad.ill.const", WIDTH'(out_illegal), 32'd1);
    loadOne("dec11", 2'b11, 6'b100000);
    checkOutput("dec11.ill.const", WIDTH'(out_illegal), 32'd1);

    // Reset while stalled drops the held instruction without a clock edge.
    setIdle();
    ex_stall = 1;
    applyStimulus("prerst");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid", WIDTH'(out_valid), 0);
    setIdle();
    @(negedge clk);
    doReset();

    // Randomized traffic with a small register range, so hits are frequent.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(99) < 80);
      flush      = ($urandom_range(99) < 8);
      ex_stall   = ($urandom_range(99) < 35);
      in_aluop   = 2'($urandom_range(3));
      case ($urandom_range(6))
        0: in_funct = 6'b100000;
        1: in_funct = 6'b100010;
        2: in_funct = 6'b100100;
        3: in_funct = 6'b100101;
        4: in_funct = 6'b101010;
        default: in_funct = 6'($urandom);
      endcase
      in_rs_addr = 5'($urandom_range(5));
      in_rt_addr = 5'($urandom_range(5));
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
      in_alusrc  = 1'($urandom_range(1));
      in_rd_addr = 5'($urandom);
      exmem_we   = 1'($urandom_range(1));
      exmem_addr = 5'($urandom_range(5));
      exmem_data = $urandom;
      memwb_we   = 1'($urandom_range(1));
      memwb_addr = 5'($urandom_range(5));
      memwb_data = $urandom;
      applyStimulus("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

- **Role:** ID/EX pipeline stage directly upstream of the ALU.
- **Inputs:** decoded operand fields from the register-file read.
- **Function:**
  - Resolves data hazards by forwarding from the EX/MEM and MEM/WB buses.
  - Selects register or immediate for the second operand.
  - Decodes ALUOp/funct into the 4-bit ALU control code.
- **Outputs:** registered, valid-qualified `Read_data_1`, `Read_data_2` and `ALUControl`, which drive the ALU ports of the same names.
- **Flow control:** a valid/ready handshake, plus a flush for branch mispredicts.

## Interface
- `WIDTH`, default 32: datapath width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream holds a decoded instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_aluop` in 2: main-decoder ALUOp.
- `in_funct` in 6: instruction funct field.
- `in_rs_addr`, `in_rt_addr` in 5 each: source register numbers.
- `in_rs_data`, `in_rt_data` in WIDTH each: register-file read data.
- `in_imm` in WIDTH: sign-extended immediate.
- `in_alusrc` in 1: 1 selects `in_imm` as operand 2.
- `in_rd_addr` in 5: destination register, passed through.
- `flush` in 1: kill the held/incoming instruction.
- `ex_stall` in 1: downstream cannot consume this cycle.
- `exmem_we`, `exmem_addr`[5], `exmem_data`[WIDTH] in: EX/MEM forwarding bus.
- `memwb_we`, `memwb_addr`[5], `memwb_data`[WIDTH] in: MEM/WB forwarding bus.
- `out_valid` out 1: outputs hold a live instruction.
- `Read_data_1`, `Read_data_2` out WIDTH each: ALU operands.
- `ALUControl` out 4: ALU operation code.
- `out_rd_addr` out 5: registered destination.
- `out_illegal` out 1: unsupported ALUOp/funct combination.

## Operation
**Handshake**
- `in_ready = !out_valid || !ex_stall`. It is combinational.
- Load occurs when `in_valid && in_ready`.

**Per-edge priority**
1. `flush`: `out_valid` ← 0. All other registers are don't-care.
2. Load: all outputs are captured and `out_valid` ← 1.
3. `in_ready && !in_valid`: `out_valid` ← 0 (bubble).
4. Otherwise, hold.

**Forwarding value**
- Applies at capture, per source address `a`.
- If `a == 0`, the raw data is used.
- Else, if `exmem_we && exmem_addr == a`, use `exmem_data`.
- Else, if `memwb_we && memwb_addr == a`, use `memwb_data`.
- Else, use the raw read data.

**Hold refresh**
- Applies while `out_valid && ex_stall && !flush`.
- Each held operand re-applies the same forwarding rule against its stored source address. A write landing during the stall must be seen.
- Operand 2 is never refreshed when its stored `alusrc` = 1.

**Operand 2**
- `in_alusrc` ? `in_imm` : forwarded rt.

**ALUControl decode (registered)**
- ALUOp 00 → 0010 (add).
- ALUOp 01 → 0110 (sub).
- ALUOp 10 decodes by funct:
  - 100000 → 0010 (add).
  - 100010 → 0110 (sub).
  - 100100 → 0000 (and).
  - 100101 → 0001 (or).
  - 101010 → 0111 (slt).
- Any other funct, or ALUOp 11 → 0010 with `out_illegal` = 1.
- `out_illegal` = 0 on every legal decode.

## Timing
- **Reset values:** `out_valid`=0, `Read_data_1`=0, `Read_data_2`=0, `ALUControl`=0000, `out_rd_addr`=0, `out_illegal`=0.
- **Latency:** 1 cycle from accepted input to outputs.
- **Throughput:** one instruction per cycle when `ex_stall`=0.
- **Simultaneous flush and in_valid:** the input is dropped and `in_ready` is still asserted (it is consumed and killed).
- **Reset mid-stall:** the held instruction is discarded immediately (asynchronous reset).
- **Outputs while `out_valid`=0:** hold their last value; the consumer ignores them.
- **Address 0 writes:** a write to address 0 on either bus never forwards.

## Configuration
- **Macro:** `ALU_OPERAND_FWD_EN`.
- **Defined:**
  - Forwarding and hold refresh operate as specified.
- **Undefined:**
  - Both forwarding buses are ignored and operands are the raw `in_rs_data`/`in_rt_data`.
  - No hold refresh.
  - The ports remain present.

## Test plan
- **Reset then single add:** `rst_n` low, then release; `in_aluop`=10, funct=100000, rs data 5, rt data 7. Next cycle: `out_valid`=1, `Read_data_1`=5, `Read_data_2`=7, `ALUControl`=0010.
- **Forward priority:** rs_addr=3, `exmem` writes 3←0xAA and `memwb` writes 3←0xBB in the same cycle. Result: `Read_data_1`=0xAA. With `ALU_OPERAND_FWD_EN` undefined, the result is the raw rs data instead.
- **Address 0:** rs_addr=0, `exmem` writes 0←0xFF. Result: `Read_data_1` equals the raw rs data.
- **Stall refresh:**
  - Load rt_addr=4 (alusrc=0), then assert `ex_stall` for 2 cycles.
  - Drive `memwb` 4←0x1234 in stall cycle 1.
  - Check: `Read_data_2`=0x1234, `in_ready`=0 throughout the stall, and `out_valid` stays 1.
- **Flush vs load:** `flush`=1 and `in_valid`=1 in the same cycle. Result: next cycle `out_valid`=0 and `in_ready` was 1.
- **Decode sweep:**
  - ALUOp 00 → 0010.
  - ALUOp 01 → 0110.
  - Funct 100100/100101/101010 → 0000/0001/0111.
  - Funct 000000 → 0010 with `out_illegal`=1.
  - ALUOp 11 → 0010 with `out_illegal`=1.
